biss_c_slave: RTL and testbench

BISS_C_SLAVE -- requirements
Module: biss_c_slave

---
 rtl/biss_c_pkg.sv | 26 ++
 rtl/biss_c_slave_crc.sv | 33 +++
 rtl/biss_c_slave.sv | 202 ++++++++++++++++++++
 tb/tb_biss_c_slave.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/biss_c_pkg.sv
// Shared types and constants for the BiSS-C slave.
package biss_c_pkg;

    localparam int unsigned   CRC_W            = 6;
    localparam logic [6:0]    CRC_POLY         = 7'h43;  // x^6 + x + 1
    localparam int unsigned   DEF_TIMEOUT_CLKS = 2000;
    localparam int unsigned   BIT_CNT_W        = 6;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ACK,
        ST_START,
        ST_CDS,
        ST_DATA,
        ST_ERR,
        ST_WARN,
        ST_CRC,
        ST_TIMEOUT
    } biss_state_e;

    // Saturating increment for the bit counter.
    function automatic logic [BIT_CNT_W-1:0] sat_inc_bits(input logic [BIT_CNT_W-1:0] v);
        return (v == {BIT_CNT_W{1'b1}}) ? v : v + BIT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/biss_c_slave_crc.sv
// Serial CRC-6 engine, one bit per strobe, synchronous clear, seed 0.
module CRC_Unit
    import biss_c_pkg::*;
(
    input  logic             CLK,
    input  logic             CLEAR,
    input  logic             BITVAL,
    input  logic             BITSTRB,
    output logic [CRC_W-1:0] CRC
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;
    logic             fb_c;

    // Next CRC value: shift left, fold the polynomial in on feedback.
    always_comb begin
        crc_d = crc_q;
        fb_c  = crc_q[CRC_W-1] ^ BITVAL;
        if (BITSTRB) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb_c ? CRC_POLY[CRC_W-1:0] : '0);
        end
    end

    // CRC register.
    always_ff @(posedge CLK) begin
        if (CLEAR) crc_q <= '0;
        else       crc_q <= crc_d;
    end

    assign CRC = crc_q;

endmodule

// File: rtl/biss_c_slave.sv
// BiSS-C slave: frames a latched position word onto SLO under MA clocking.
module biss_c_slave
    import biss_c_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 32,
    parameter int unsigned ACK_CYCLES   = 1,
    parameter int unsigned TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
    input  logic                 CLK,
    input  logic                 CLEAR,
    input  logic                 MA,
    output logic                 SLO,
    input  logic [DATA_BITS-1:0] POS_DATA,
    input  logic                 ERR_N,
    input  logic                 WARN_N,
    output logic                 LATCH,
    output logic                 BUSY,
    output logic                 FRAME_DONE
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CLKS + 1);

    biss_state_e            state_q, state_d;
    logic                   ma_s1_q, ma_s2_q, ma_s3_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   err_q, err_d, warn_q, warn_d;
    logic                   slo_q, slo_d;
    logic                   latch_q, latch_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   ma_rise_c, ma_fall_c, to_hit_c;
    logic                   crc_val_c, crc_strb_c, crc_clr_c;
    logic [CRC_W-1:0]       crc;
    logic [CRC_W-1:0]       crc_rot_c;

    assign ma_rise_c = ma_s2_q & ~ma_s3_q;
    assign ma_fall_c = ~ma_s2_q & ma_s3_q;
    assign to_hit_c  = ma_s2_q && (to_cnt_q == TO_W'(TIMEOUT_CLKS - 1));
    assign crc_rot_c = crc << bit_cnt_q[2:0];

    CRC_Unit u_crc (
        .CLK     (CLK),
        .CLEAR   (CLEAR | crc_clr_c),
        .BITVAL  (crc_val_c),
        .BITSTRB (crc_strb_c),
        .CRC     (crc)
    );

    // Next-state, SLO bit selection, CRC strobes and MA-high timeout counting.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        err_d      = err_q;
        warn_d     = warn_q;
        slo_d      = slo_q;
        latch_d    = 1'b0;
        done_d     = 1'b0;
        crc_val_c  = 1'b0;
        crc_strb_c = 1'b0;
        crc_clr_c  = 1'b0;

        // Counts CLKs of synced MA high while a frame or timeout is in progress.
        if (state_q == ST_IDLE || !ma_s2_q)      to_cnt_d = '0;
        else if (to_cnt_q != TO_W'(TIMEOUT_CLKS)) to_cnt_d = to_cnt_q + TO_W'(1);
        else                                      to_cnt_d = to_cnt_q;

        case (state_q)
            ST_IDLE: begin
                slo_d = 1'b1;
                if (ma_fall_c) begin
                    data_d    = POS_DATA;
                    err_d     = ERR_N;
                    warn_d    = WARN_N;
                    latch_d   = 1'b1;
                    crc_clr_c = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ST_ACK;
                end
            end
            ST_ACK: begin
                if (ma_rise_c) begin
                    slo_d     = 1'b0;
                    bit_cnt_d = sat_inc_bits(bit_cnt_q);
                    if (bit_cnt_q == BIT_CNT_W'(ACK_CYCLES - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = ST_START;
                    end
                end
            end
            ST_START: begin
                if (ma_rise_c) begin
                    slo_d   = 1'b1;
                    state_d = ST_CDS;
                end
            end
            ST_CDS: begin
                if (ma_rise_c) begin
                    slo_d     = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (ma_rise_c) begin
                    slo_d      = data_q[DATA_BITS-1];
                    data_d     = {data_q[DATA_BITS-2:0], 1'b0};
                    crc_val_c  = data_q[DATA_BITS-1];
                    crc_strb_c = 1'b1;
                    bit_cnt_d  = sat_inc_bits(bit_cnt_q);
                    if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                if (ma_rise_c) begin
                    slo_d      = err_q;
                    crc_val_c  = err_q;
                    crc_strb_c = 1'b1;
                    state_d    = ST_WARN;
                end
            end
            ST_WARN: begin
                if (ma_rise_c) begin
                    slo_d      = warn_q;
                    crc_val_c  = warn_q;
                    crc_strb_c = 1'b1;
                    bit_cnt_d  = '0;
                    state_d    = ST_CRC;
                end
            end
            ST_CRC: begin
                if (ma_rise_c) begin
                    slo_d     = ~crc_rot_c[CRC_W-1];
                    bit_cnt_d = sat_inc_bits(bit_cnt_q);
                    if (bit_cnt_q == BIT_CNT_W'(CRC_W - 1)) begin
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_TIMEOUT;
                    end
                end
            end
            ST_TIMEOUT: begin
                // Bit period after the last CRC bit is driven low; falling edges are ignored.
                if (ma_rise_c) slo_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        // MA held high long enough ends the frame (normal end or abort).
        if (state_q != ST_IDLE && to_hit_c) begin
            slo_d   = 1'b1;
            done_d  = 1'b0;
            state_d = ST_IDLE;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, synchronizer and output registers.
    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            state_q   <= ST_IDLE;
            ma_s1_q   <= 1'b1;
            ma_s2_q   <= 1'b1;
            ma_s3_q   <= 1'b1;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            data_q    <= '0;
            err_q     <= 1'b1;
            warn_q    <= 1'b1;
            slo_q     <= 1'b1;
            latch_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ma_s1_q   <= MA;
            ma_s2_q   <= ma_s1_q;
            ma_s3_q   <= ma_s2_q;
            bit_cnt_q <= bit_cnt_d;
            to_cnt_q  <= to_cnt_d;
            data_q    <= data_d;
            err_q     <= err_d;
            warn_q    <= warn_d;
            slo_q     <= slo_d;
            latch_q   <= latch_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign SLO        = slo_q;
    assign LATCH      = latch_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_biss_c_slave.sv
// Directed scoreboard bench for biss_c_slave (8-bit and 32-bit instances).
module tb_biss_c_slave;

    localparam int unsigned TO_CLKS = 2000;
    localparam int unsigned ACK_N   = 1;

    logic        clk = 1'b0;
    logic        clear;
    logic        ma8, ma32;
    logic [7:0]  pos8;
    logic [31:0] pos32;
    logic        err8, warn8, err32, warn32;
    logic        slo8, slo32, lat8, lat32, busy8, busy32, done8, done32;

    int nvec  = 0;
    int nfail = 0;
    int lat_cnt8 = 0, lat_cnt32 = 0, done_cnt8 = 0, done_cnt32 = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    biss_c_slave #(.DATA_BITS(8), .ACK_CYCLES(ACK_N), .TIMEOUT_CLKS(TO_CLKS)) u8 (
        .CLK(clk), .CLEAR(clear), .MA(ma8), .SLO(slo8), .POS_DATA(pos8),
        .ERR_N(err8), .WARN_N(warn8), .LATCH(lat8), .BUSY(busy8), .FRAME_DONE(done8)
    );

    biss_c_slave #(.DATA_BITS(32), .ACK_CYCLES(ACK_N), .TIMEOUT_CLKS(TO_CLKS)) u32 (
        .CLK(clk), .CLEAR(clear), .MA(ma32), .SLO(slo32), .POS_DATA(pos32),
        .ERR_N(err32), .WARN_N(warn32), .LATCH(lat32), .BUSY(busy32), .FRAME_DONE(done32)
    );

    // Pulse counters for LATCH and FRAME_DONE.
    always @(posedge clk) begin
        if (lat8)   lat_cnt8   <= lat_cnt8 + 1;
        if (lat32)  lat_cnt32  <= lat_cnt32 + 1;
        if (done8)  done_cnt8  <= done_cnt8 + 1;
        if (done32) done_cnt32 <= done_cnt32 + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ma(input bit sel, input logic v);
        if (sel) ma32 = v; else ma8 = v;
    endtask

    function automatic logic slo_of(input bit sel);
        return sel ? slo32 : slo8;
    endfunction
    function automatic logic busy_of(input bit sel);
        return sel ? busy32 : busy8;
    endfunction
    function automatic logic done_of(input bit sel);
        return sel ? done32 : done8;
    endfunction
    function automatic int lat_cnt_of(input bit sel);
        return sel ? lat_cnt32 : lat_cnt8;
    endfunction
    function automatic int done_cnt_of(input bit sel);
        return sel ? done_cnt32 : done_cnt8;
    endfunction

    // Reference CRC-6 (x^6+x+1, seed 0) over data, ERR_N, WARN_N; returns the inverted value.
    function automatic logic [5:0] crc_tx(input logic [39:0] d, input int n, input logic e, input logic w);
        logic [5:0] c;
        logic       b;
        c = 6'd0;
        for (int i = n + 1; i >= 0; i--) begin
            if (i >= 2) b = d[i-2];
            else if (i == 1) b = e;
            else b = w;
            if (c[5] ^ b) c = {c[4:0], 1'b0} ^ 6'h03;
            else          c = {c[4:0], 1'b0};
        end
        return ~c;
    endfunction

    // Drives one frame. nrise=0: all bits plus one timeout-low bit; else stop after nrise MA rising edges.
    task automatic run_frame(input bit sel, input int nbits, input logic [39:0] pos, input logic e,
                             input logic w, input logic [5:0] crc_bits, input bit chg, input int nrise);
        int   total, last_crc, lc;
        logic exp;
        exp_q.delete();
        for (int i = 0; i < int'(ACK_N); i++) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        for (int i = nbits - 1; i >= 0; i--) exp_q.push_back(pos[i]);
        exp_q.push_back(e);
        exp_q.push_back(w);
        for (int i = 5; i >= 0; i--) exp_q.push_back(crc_bits[i]);
        last_crc = exp_q.size() - 1;
        if (nrise == 0) exp_q.push_back(1'b0);
        total = (nrise == 0) ? exp_q.size() : nrise;

        if (sel) begin pos32 = pos[31:0]; err32 = e; warn32 = w; end
        else     begin pos8  = pos[7:0];  err8  = e; warn8  = w; end

        // Falling edge starts the frame; LATCH shows on the third CLK.
        lc = lat_cnt_of(sel);
        set_ma(sel, 1'b0);
        wait_edges(3);
        check("latch_pulse", {63'd0, (sel ? lat32 : lat8)}, 64'd1);
        check("busy_in_frame", {63'd0, busy_of(sel)}, 64'd1);
        if (chg) begin
            wait_edges(1);
            if (sel) pos32 = '0; else pos8 = '0;
            wait_edges(6);
        end else begin
            wait_edges(7);
        end

        for (int r = 0; r < total; r++) begin
            set_ma(sel, 1'b1);
            wait_edges(3);
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 64'd1, 64'd0);
                exp = 1'bx;
            end else begin
                exp = exp_q.pop_front();
            end
            check($sformatf("slo_bit%0d", r), {63'd0, slo_of(sel)}, {63'd0, exp});
            if (r == last_crc) check("frame_done", {63'd0, done_of(sel)}, 64'd1);
            if (r == total - 1) break;
            wait_edges(7);
            lc = lat_cnt_of(sel);
            set_ma(sel, 1'b0);
            wait_edges(10);
            if (r >= last_crc) check("no_latch_in_timeout", lat_cnt_of(sel), lc);
        end
    endtask

    // MA is held high since the last rising edge (3 CLKs ago); SLO must rise TO_CLKS+2 CLKs after it.
    task automatic measure_to(input bit sel, input string tag);
        int n;
        n = 3;
        while (slo_of(sel) !== 1'b1 && n < int'(TO_CLKS) + 50) begin
            wait_edges(1);
            n++;
        end
        check(tag, n, TO_CLKS + 2);
        check({tag, "_busy"}, {63'd0, busy_of(sel)}, 64'd0);
    endtask

    initial begin
        int dc;
        clear = 1'b1; ma8 = 1'b1; ma32 = 1'b1;
        pos8 = '0; pos32 = '0; err8 = 1'b1; warn8 = 1'b1; err32 = 1'b1; warn32 = 1'b1;
        wait_edges(5);
        check("rst_slo8", {63'd0, slo8}, 64'd1);
        check("rst_busy8", {63'd0, busy8}, 64'd0);
        check("rst_latch8", {63'd0, lat8}, 64'd0);
        check("rst_done8", {63'd0, done8}, 64'd0);
        check("rst_slo32", {63'd0, slo32}, 64'd1);
        clear = 1'b0;
        wait_edges(5);

        // Zero data, no error/warning: known CRC 111010, then timeout-low and release.
        run_frame(1'b0, 8, 40'h00, 1'b1, 1'b1, 6'b111010, 1'b0, 0);
        measure_to(1'b0, "timeout_a");
        check("done_cnt_a", done_cnt8, 1);

        // Zero data with both flags active: CRC all ones.
        run_frame(1'b0, 8, 40'h00, 1'b0, 1'b0, 6'b111111, 1'b0, 0);
        measure_to(1'b0, "timeout_b");
        check("done_cnt_b", done_cnt8, 2);

        // 32-bit word changed right after LATCH must still go out intact.
        run_frame(1'b1, 32, 40'hAA55AA55, 1'b1, 1'b0, crc_tx(40'hAA55AA55, 32, 1'b1, 1'b0), 1'b1, 0);
        measure_to(1'b1, "timeout_c");
        check("done_cnt_c", done_cnt32, 1);

        // MA stops high mid-DATA: abort with no FRAME_DONE.
        dc = done_cnt8;
        run_frame(1'b0, 8, 40'h00, 1'b1, 1'b1, 6'b111010, 1'b0, 6);
        measure_to(1'b0, "abort");
        check("abort_no_done", done_cnt8, dc);
        wait_edges(20);

        run_frame(1'b0, 8, 40'hA5, 1'b1, 1'b0, crc_tx(40'hA5, 8, 1'b1, 1'b0), 1'b0, 0);
        measure_to(1'b0, "timeout_after_abort");

        // CLEAR pulsed mid-DATA.
        run_frame(1'b0, 8, 40'h00, 1'b1, 1'b1, 6'b111010, 1'b0, 5);
        wait_edges(2);
        clear = 1'b1;
        wait_edges(1);
        check("clear_slo", {63'd0, slo8}, 64'd1);
        check("clear_busy", {63'd0, busy8}, 64'd0);
        clear = 1'b0;
        wait_edges(10);

        run_frame(1'b0, 8, 40'h3C, 1'b0, 1'b1, crc_tx(40'h3C, 8, 1'b0, 1'b1), 1'b0, 0);
        measure_to(1'b0, "timeout_after_clear");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
